// File: rtl/sorter_pkg.sv
// Shared sizing defaults and FSM encoding for the batch sorter controller.
package sorter_pkg;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int LW    = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SORT  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // A batch must hold at least one entry and fit in the buffer.
    function automatic logic len_ok(input logic [LW-1:0] len, input int depth);
        return (len != '0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/sorter_ctrl_if.sv
// Value-FIFO read port and sorted output stream of the sorter controller.
interface sorter_ctrl_if #(
    parameter int DW = sorter_pkg::DW
);

    logic          val_empty;
    logic          val_rd_en;
    logic [DW-1:0] val_rd_data;

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        input  val_empty, val_rd_data, m_ready,
        output val_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output val_empty, val_rd_data, m_ready,
        input  val_rd_en, m_data, m_valid, m_last
    );

endinterface

// File: rtl/sorter_ctrl_cmp_swap.sv
// Unsigned ascending compare-swap; equal inputs pass through unswapped.
module cmp_swap #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);

    logic swap;

    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sorter_ctrl.sv
// Batch sorter: loads up to DEPTH values from a FIFO, sorts them with
// odd-even transposition (one phase per cycle) and streams them out ascending.
module sorter_ctrl import sorter_pkg::*; #(
    parameter int DEPTH = sorter_pkg::DEPTH,
    parameter int DW    = sorter_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] cfg_len,
    input  logic          abort,
    sorter_ctrl_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] issued;
    logic [LW-1:0] cap_idx;
    logic [LW-1:0] phase_cnt;
    logic [LW-1:0] rd_idx;
    logic          rd_pending;
    logic          pop;
    logic          odd_phase;
    logic          at_last;

    logic [DW-1:0] buf_q     [DEPTH];
    logic [DW-1:0] sort_next [DEPTH];
    logic [DW-1:0] cs_lo     [DEPTH/2];
    logic [DW-1:0] cs_hi     [DEPTH/2];

    assign pop       = (state == ST_LOAD) && !bus.val_empty && (issued < len) && !abort;
    assign odd_phase = phase_cnt[0];
    assign at_last   = (rd_idx == len - LW'(1));

    assign bus.val_rd_en = pop;
    assign bus.m_valid   = (state == ST_DRAIN);
    assign bus.m_data    = bus.m_valid ? buf_q[rd_idx[IW-1:0]] : '0;
    assign bus.m_last    = bus.m_valid && at_last;

    assign busy = (state != ST_IDLE);
    assign done = bus.m_last && bus.m_ready && !abort;

    // Comparator g serves pair (2g,2g+1) on even phases and (2g+1,2g+2) on odd ones.
    for (genvar g = 0; g < DEPTH/2; g++) begin : g_cs
        localparam int OH = (2*g + 2 < DEPTH) ? 2*g + 2 : 2*g + 1;

        logic [DW-1:0] cs_a;
        logic [DW-1:0] cs_b;

        assign cs_a = odd_phase ? buf_q[2*g + 1] : buf_q[2*g];
        assign cs_b = odd_phase ? buf_q[OH]      : buf_q[2*g + 1];

        cmp_swap #(.DW(DW)) u_cs (
            .a  (cs_a),
            .b  (cs_b),
            .lo (cs_lo[g]),
            .hi (cs_hi[g])
        );
    end

    // A pair only swaps when its upper index lies inside the current batch.
    for (genvar k = 0; k < DEPTH; k++) begin : g_next
        localparam int EI   = k / 2;
        localparam int EH   = k | 1;
        localparam int OI   = (k > 0) ? (k - 1) / 2 : 0;
        localparam int OH   = (k % 2 == 1) ? k + 1 : k;
        localparam bit OACT = (k > 0) && (OH < DEPTH);

        assign sort_next[k] =
            (!odd_phase && (EH < int'(len)))        ? ((k % 2 == 0) ? cs_lo[EI] : cs_hi[EI]) :
            (odd_phase && OACT && (OH < int'(len))) ? ((k % 2 == 1) ? cs_lo[OI] : cs_hi[OI]) :
                                                      buf_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            issued     <= '0;
            cap_idx    <= '0;
            phase_cnt  <= '0;
            rd_idx     <= '0;
            rd_pending <= 1'b0;
            err        <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            err        <= 1'b0;
            rd_pending <= pop;
            if (pop) begin
                issued <= issued + LW'(1);
            end

            if (abort && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                rd_pending <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (len_ok(cfg_len, DEPTH)) begin
                                len       <= cfg_len;
                                issued    <= '0;
                                cap_idx   <= '0;
                                phase_cnt <= '0;
                                rd_idx    <= '0;
                                state     <= ST_LOAD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end

                    // Read data trails its pop by one cycle, so capture lags issue.
                    ST_LOAD: begin
                        if (rd_pending) begin
                            buf_q[cap_idx[IW-1:0]] <= bus.val_rd_data;
                            cap_idx                <= cap_idx + LW'(1);
                            if (cap_idx == len - LW'(1)) begin
                                phase_cnt <= '0;
                                state     <= ST_SORT;
                            end
                        end
                    end

                    ST_SORT: begin
                        buf_q     <= sort_next;
                        phase_cnt <= phase_cnt + LW'(1);
                        if (phase_cnt == len - LW'(1)) begin
                            rd_idx <= '0;
                            state  <= ST_DRAIN;
                        end
                    end

                    ST_DRAIN: begin
                        if (bus.m_ready) begin
                            if (at_last) begin
                                state <= ST_IDLE;
                            end else begin
                                rd_idx <= rd_idx + LW'(1);
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sorter_ctrl.sv
// Directed bench for sorter_ctrl with a behavioural value FIFO and stream sink.
module tb_sorter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] cfg_len;
    logic       busy;
    logic       done;
    logic       err;

    sorter_ctrl_if #(.DW(8)) bus();

    sorter_ctrl #(.DEPTH(8), .DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cfg_len (cfg_len),
        .abort   (abort),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         pops   = 0;

    // Read data appears the cycle after the pop, like a registered FIFO.
    assign bus.val_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.val_rd_en) begin
            bus.val_rd_data <= fifo_mem[rd_ptr];
            rd_ptr          <= rd_ptr + 8'd1;
            pops            <= pops + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         total_cycles;
    int         done_cnt;
    int         pops_before;
    logic [7:0] stim_vals [$];
    logic [7:0] exp_vals  [$];
    logic [7:0] got       [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic push_stim();
        foreach (stim_vals[i]) begin
            fifo_mem[wr_ptr] = stim_vals[i];
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] n);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = n;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Runs until done (bounded), recording handshaked data and checking stalls hold.
    task automatic collect(input int n, input bit toggle, input int budget);
        bit         ready_ph   = 1'b1;
        bit         stall_prev = 1'b0;
        bit         finished   = 1'b0;
        logic [7:0] held_data  = 8'd0;
        logic       held_last  = 1'b0;
        got.delete();
        done_cnt     = 0;
        total_cycles = 0;
        for (int c = 0; c < budget && !finished; c++) begin
            bus.m_ready = toggle ? ready_ph : 1'b1;
            ready_ph    = ~ready_ph;
            #1;
            if (stall_prev) begin
                checkOutput("hold_data", 32'(bus.m_data), 32'(held_data));
                checkOutput("hold_last", 32'(bus.m_last), 32'(held_last));
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            held_data  = bus.m_data;
            held_last  = bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                checkOutput("m_last", 32'(bus.m_last), 32'(got.size() == n - 1));
                got.push_back(bus.m_data);
            end
            if (done) begin
                done_cnt++;
                total_cycles = c + 1;
                finished     = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic check_result(input string tag);
        checkOutput({tag, "_count"}, 32'(got.size()), 32'(exp_vals.size()));
        for (int i = 0; i < exp_vals.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp_vals[i]));
        end
    endtask

    initial begin
        int w;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_len     = 4'd0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_outs", 32'({bus.val_rd_en, bus.m_valid, bus.m_last, done, err, bus.m_data}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        stim_vals = '{8'h5A, 8'h03, 8'hFF, 8'h10};
        exp_vals  = '{8'h03, 8'h10, 8'h5A, 8'hFF};
        push_stim();
        applyStimulus(4'd4);
        #1;
        checkOutput("busy_load", 32'(busy), 32'd1);
        collect(4, 1'b0, 60);
        check_result("sort4");
        checkOutput("latency4", 32'(total_cycles), 32'd13);
        #1;
        checkOutput("idle4", 32'(busy), 32'd0);

        stim_vals = '{8'd7, 8'd7, 8'd1, 8'd9, 8'd0, 8'd7, 8'd2, 8'd2};
        exp_vals  = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd7, 8'd7, 8'd7, 8'd9};
        push_stim();
        applyStimulus(4'd8);
        collect(8, 1'b1, 200);
        check_result("sort8");
        #1;
        checkOutput("idle8", 32'(busy), 32'd0);

        pops_before = pops;
        applyStimulus(4'd0);
        #1;
        checkOutput("err_len0", 32'(err), 32'd1);
        checkOutput("busy_len0", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("err_pulse0", 32'(err), 32'd0);
        applyStimulus(4'd9);
        #1;
        checkOutput("err_len9", 32'(err), 32'd1);
        checkOutput("busy_len9", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("err_pulse9", 32'(err), 32'd0);
        checkOutput("no_pop_err", 32'(pops - pops_before), 32'd0);

        @(negedge clk);
        start   = 1'b1;
        cfg_len = 4'd3;
        abort   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        #1;
        checkOutput("abort_start_busy", 32'(busy), 32'd0);
        checkOutput("abort_start_err", 32'(err), 32'd0);

        stim_vals = '{8'h80, 8'h01};
        exp_vals  = '{8'h01, 8'h01, 8'h7F, 8'h80};
        push_stim();
        pops_before = pops;
        applyStimulus(4'd4);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("stall_busy", 32'(busy), 32'd1);
        checkOutput("stall_pops", 32'(pops - pops_before), 32'd2);
        checkOutput("stall_rd_en", 32'(bus.val_rd_en), 32'd0);
        checkOutput("stall_valid", 32'(bus.m_valid), 32'd0);
        stim_vals = '{8'h7F, 8'h01};
        push_stim();
        collect(4, 1'b0, 60);
        check_result("partial");

        stim_vals = '{8'h04, 8'h03, 8'h02, 8'h01};
        push_stim();
        applyStimulus(4'd4);
        bus.m_ready = 1'b1;
        #1;
        w = 0;
        while (!bus.m_valid && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        checkOutput("abort_reach_drain", 32'(bus.m_valid), 32'd1);
        checkOutput("abort_first", 32'(bus.m_data), 32'h01);
        @(negedge clk);
        abort = 1'b1;
        #1;
        checkOutput("abort_data2", 32'(bus.m_data), 32'h02);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_nodone", 32'(done), 32'd0);

        stim_vals = '{8'hC0, 8'h0A, 8'h55};
        exp_vals  = '{8'h0A, 8'h55, 8'hC0};
        push_stim();
        applyStimulus(4'd3);
        collect(3, 1'b0, 60);
        check_result("post_abort");
        checkOutput("latency3", 32'(total_cycles), 32'd10);

        stim_vals = '{8'h31, 8'h12, 8'hE0, 8'h05, 8'h77, 8'h40, 8'h99, 8'h01};
        push_stim();
        applyStimulus(4'd8);
        repeat (11) @(negedge clk);
        #1;
        checkOutput("mid_sort_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_sort_outs",
                    32'({busy, bus.val_rd_en, bus.m_valid, bus.m_last, done, err, bus.m_data}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_busy_after", 32'(busy), 32'd0);

        stim_vals = '{8'h42};
        exp_vals  = '{8'h42};
        push_stim();
        applyStimulus(4'd1);
        collect(1, 1'b0, 30);
        check_result("len1");
        checkOutput("latency1", 32'(total_cycles), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorter_ctrl.md
SORTER_CTRL -- requirements
Module: sorter_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: maximum entries per sort batch.
REQ-002 SHALL have parameter DW, default 8: width of one value entry.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a batch.
REQ-006 SHALL have port cfg_len, input, 4: batch length, sampled with start.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the current batch.
REQ-008 SHALL have port val_empty, input, 1: value FIFO empty flag.
REQ-009 SHALL have port val_rd_en, output, 1: value FIFO pop strobe.
REQ-010 SHALL have port val_rd_data, input, DW: FIFO read data, valid one cycle after val_rd_en.
REQ-011 SHALL have ports m_data (output, DW), m_valid (output, 1), m_ready (input, 1), m_last (output, 1): sorted output stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SORT, DRAIN; busy = (state != IDLE).
REQ-014 IDLE: start with 1 <= cfg_len <= DEPTH SHALL latch len, clear indices, go to LOAD next cycle.
REQ-015 IDLE: start with cfg_len = 0 or > DEPTH SHALL pulse err for one cycle and stay in IDLE.
REQ-016 start outside IDLE SHALL be ignored, with no err pulse.
REQ-017 LOAD: val_rd_en SHALL be asserted only when !val_empty and issued < len; at most len pops per batch.
REQ-018 LOAD: each pop's data SHALL be written to buf[cap_idx] one cycle after the pop; when cap_idx reaches len, the next state SHALL be SORT.
REQ-019 LOAD with val_empty held high SHALL stall indefinitely; no timeout.
REQ-020 SORT: SHALL perform exactly len odd-even transposition phases, one per cycle, starting with the even phase.
REQ-021 SORT: compare-swap SHALL be unsigned and ascending, acting only on indices < len; equal values are not swapped.
REQ-022 DRAIN: m_valid = 1 and m_data = buf[rd_idx]; rd_idx SHALL advance only on m_valid && m_ready.
REQ-023 m_data and m_last SHALL be held stable while m_valid && !m_ready.
REQ-024 m_last SHALL be high exactly when rd_idx == len-1.
REQ-025 The handshake on the last entry SHALL return the FSM to IDLE and pulse done in the same cycle as that handshake.
REQ-026 Batch latency with no stalls SHALL be len+1 LOAD cycles + len SORT cycles + len DRAIN cycles.
REQ-027 abort in any non-IDLE state SHALL force IDLE next cycle, deassert m_valid and val_rd_en, and discard an in-flight read; no done pulse.
REQ-028 abort together with start in IDLE: abort SHALL win and start is dropped.
REQ-029 len = 1 SHALL take one no-op SORT cycle.

Reset
REQ-030 rst high SHALL immediately force state IDLE and all indices/counters to 0.
REQ-031 rst high SHALL immediately clear buf to 0 and drive val_rd_en, m_valid, m_last, m_data, busy, done and err to 0.
REQ-032 Reset mid-batch SHALL discard the batch; FIFO entries already popped are lost.

Structure
REQ-033 Package sorter_pkg SHALL hold DEPTH, DW and the FSM state encoding.
REQ-034 The compare-swap SHALL be a sub-module cmp_swap (two DW inputs, min/max outputs), instantiated DEPTH/2 times.

Verification
REQ-035 FIFO preloaded 0x5A,0x03,0xFF,0x10; start, cfg_len=4; m_ready=1 -> stream 0x03,0x10,0x5A,0xFF; m_last on 0xFF; done pulse; total 13 cycles from start.
REQ-036 cfg_len=8, values 7,7,1,9,0,7,2,2; m_ready toggled 1/0 each cycle -> 0,1,2,2,7,7,7,9 with m_data stable through each stall.
REQ-037 start with cfg_len=0, then with cfg_len=9 -> one err pulse each; busy stays 0; no val_rd_en.
REQ-038 cfg_len=4 with only 2 entries in FIFO -> 2 pops then stall in LOAD; push 2 more -> completes with correct sorted order.
REQ-039 abort asserted on the second DRAIN handshake -> IDLE next cycle; m_valid=0; no done; new batch sorts correctly.
REQ-040 rst asserted mid-SORT -> all outputs 0 within the same cycle; busy=0 after release.
